// File: rtl/paraleloserie_idl_tx.sv
// ============================================================================
// Module   : paraleloserie_idl_tx
// Brief    : Parallel-to-serial link transmitter. Sends a COM alignment
//            preamble after reset, then user bytes or IDL symbols, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module paraleloserie_idl_tx #(
    parameter logic [7:0]  COM_SYM   = 8'hBC,
    parameter logic [7:0]  IDL_SYM   = 8'h7C,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       out,
    output logic       active
);

    localparam logic [0:0] ST_SYNC    = 1'b0;
    localparam logic [0:0] ST_ACTIVE  = 1'b1;
    localparam logic [3:0] C_LAST_COM = 4'(COM_COUNT - 1);

    logic [0:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_com_cnt;
    logic [7:0] r_shift;
    logic       r_out;

    logic       w_sym_end;
    logic       w_ready;
    logic [7:0] w_next_sym;

    assign w_sym_end = (r_bit_cnt == 3'd7);

    // Decoded purely from registers so the source sees a glitch-free strobe
    // that never depends on its own data/valid.
    assign w_ready = w_sym_end &&
                     ((r_state == ST_ACTIVE) || (r_com_cnt == C_LAST_COM));

    always_comb begin
        w_next_sym = COM_SYM;
        if (w_ready) begin
            w_next_sym = valid_in ? data_in : IDL_SYM;
        end
    end

    always_ff @(posedge clk32f) begin
        if (reset) begin
            r_state   <= ST_SYNC;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd0;
            r_shift   <= COM_SYM;
            r_out     <= 1'b0;
        end else begin
            r_out     <= r_shift[3'd7 - r_bit_cnt];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_sym_end) begin
                r_shift <= w_next_sym;
                if (r_state == ST_SYNC) begin
                    r_com_cnt <= r_com_cnt + 4'd1;
                    if (r_com_cnt == C_LAST_COM) begin
                        r_state <= ST_ACTIVE;
                    end
                end
            end
        end
    end

    assign ready  = w_ready;
    assign out    = r_out;
    assign active = (r_state == ST_ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_paraleloserie_idl_tx.sv
// ============================================================================
// Module   : tb_paraleloserie_idl_tx
// Brief    : Directed scoreboard bench for paraleloserie_idl_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_paraleloserie_idl_tx;

    localparam logic [7:0]  COM       = 8'hBC;
    localparam logic [7:0]  IDL       = 8'h7C;
    localparam int unsigned COM_COUNT = 4;

    logic       clk32f   = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready;
    logic       out;
    logic       active;

    int   checks = 0;
    int   errors = 0;
    int   n      = 0;     // non-reset edges since the last reset edge
    logic prev_ready = 1'b0;
    logic sb[$];          // expected serial bits, in transmit order

    paraleloserie_idl_tx #(
        .COM_SYM   (COM),
        .IDL_SYM   (IDL),
        .COM_COUNT (COM_COUNT)
    ) dut (
        .clk32f   (clk32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .out      (out),
        .active   (active)
    );

    always #5 clk32f = ~clk32f;

    function automatic logic model_ready();
        return ((n % 8) == 7) && (n >= int'(8 * COM_COUNT) - 1);
    endfunction

    task automatic check(input logic obs, input logic exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic push_sym(input logic [7:0] sym);
        for (int i = 7; i >= 0; i--) sb.push_back(sym[i]);
    endtask

    // One clock: queue whatever the upcoming edge consumes, then check outputs.
    task automatic tick();
        logic rst_edge;
        logic b;
        rst_edge = reset;
        if (!rst_edge && model_ready()) push_sym(valid_in ? data_in : IDL);
        @(posedge clk32f);
        #1;
        if (rst_edge) begin
            n = 0;
            sb.delete();
            for (int k = 0; k < int'(COM_COUNT); k++) push_sym(COM);
            prev_ready = 1'b0;
            check(out,    1'b0, "reset_out");
            check(active, 1'b0, "reset_active");
            check(ready,  1'b0, "reset_ready");
        end else begin
            n++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed empty queue expected a bit (edge %0d)", n);
            end else begin
                b = sb.pop_front();
                check(out, b, "out_bit");
            end
            check(active, (n >= int'(8 * COM_COUNT)), "active");
            check(ready,  model_ready(), "ready");
            check(prev_ready & ready, 1'b0, "ready_twice");
            prev_ready = ready;
        end
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 16 && !model_ready(); i++) tick();
        check(ready, 1'b1, "wait_ready");
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        ticks(cycles);
        reset = 1'b0;
    endtask

    initial begin
        // T1: COM preamble then IDL with nothing offered
        do_reset(2);
        ticks(40);

        // T2: single byte then idle
        wait_ready();
        data_in  = 8'hA5;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        data_in  = 8'h00;
        ticks(16);

        // T3: back-to-back bytes
        begin
            logic [7:0] bytes [3];
            bytes[0] = 8'h01;
            bytes[1] = 8'h80;
            bytes[2] = 8'hFF;
            valid_in = 1'b1;
            for (int i = 0; i < 3; i++) begin
                wait_ready();
                data_in = bytes[i];
                tick();
            end
            valid_in = 1'b0;
            ticks(16);
        end

        // T4: data offered during SYNC is ignored until the first ready
        do_reset(3);
        valid_in = 1'b1;
        data_in  = 8'hFF;
        ticks(20);
        data_in  = 8'h55;
        ticks(20);
        valid_in = 1'b0;
        ticks(16);

        // T5: reset during the third bit of a data byte
        wait_ready();
        data_in  = 8'hC3;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        ticks(2);
        do_reset(1);
        ticks(48);

        // T6: ready cadence over a long ACTIVE stretch
        ticks(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
